// File: rtl/cache_pkg.sv
// cache_pkg: FSM state encoding and request-direction constants shared by
// param_data_cache and its testbench.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EVICT = 3'd1,
        FILL  = 3'd2,
        WMEM  = 3'd3,
        DONE  = 3'd4
    } cache_state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/lru_tracker.sv
// lru_tracker: true-LRU age array for a fully-associative cache.
// Ages form a permutation of 0..LINES-1; age 0 is the most recently used line.
// The victim is the lowest-index invalid line, else the line whose age is LINES-1.
module lru_tracker #(
    parameter int LINES = 4,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic             g_clk,
    input  logic             g_clr,
    input  logic             touch,
    input  logic [IDX_W-1:0] touch_idx,
    input  logic [LINES-1:0] valid,
    output logic [IDX_W-1:0] lru_idx
);

    logic [LINES-1:0][IDX_W-1:0] age;

    // On a touch the used line becomes youngest and every younger line ages by one.
    always_ff @(posedge g_clk) begin
        if (!g_clr) begin
            for (int i = 0; i < LINES; i++) age[i] <= IDX_W'(i);
        end else if (touch) begin
            for (int i = 0; i < LINES; i++) begin
                if (IDX_W'(i) == touch_idx)
                    age[i] <= '0;
                else if (age[i] < age[touch_idx])
                    age[i] <= age[i] + IDX_W'(1);
            end
        end
    end

    // Victim pick: empty lines first (lowest index wins), otherwise the oldest line.
    always_comb begin
        lru_idx = '0;
        for (int i = LINES - 1; i >= 0; i--)
            if (age[i] == IDX_W'(LINES - 1)) lru_idx = IDX_W'(i);
        for (int i = LINES - 1; i >= 0; i--)
            if (!valid[i]) lru_idx = IDX_W'(i);
    end

endmodule

// File: rtl/param_data_cache.sv
// param_data_cache: fully-associative data cache with one-word lines, true-LRU
// replacement and a req/ack port to external data RAM.
// Build option CACHE_WRITE_BACK_EN: when defined, writes are write-back with
// per-line dirty bits and dirty victims are written out in EVICT; when
// undefined, every write goes through to memory in WMEM and EVICT is unreachable.
module param_data_cache
    import cache_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LINES  = 4,
    parameter int IDX_W  = $clog2(LINES)
) (
    input  logic              g_clk,
    input  logic              g_clr,
    input  logic              en,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  lru_idx,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    cache_state_t                 state;
    req_t                         req;
    logic [LINES-1:0][ADDR_W-1:0] tag;
    logic [LINES-1:0][DATA_W-1:0] line_data;
    logic [LINES-1:0]             valid;
    logic [LINES-1:0]             match;
    logic                         lookup_hit;
    logic [IDX_W-1:0]             lookup_idx;
    logic [IDX_W-1:0]             alloc_idx;
    logic                         victim_dirty;
    logic                         touch;

`ifdef CACHE_WRITE_BACK_EN
    logic [LINES-1:0]             dirty;
    assign victim_dirty = valid[lru_idx] & dirty[lru_idx];
`else
    assign victim_dirty = 1'b0;
`endif

    // Per-line tag compare against the live request address.
    always_comb begin
        match = '0;
        for (int i = 0; i < LINES; i++)
            match[i] = valid[i] && (tag[i] == addr);
    end

    // Encode the matching line (tags are unique, so at most one bit is set).
    always_comb begin
        lookup_hit = |match;
        lookup_idx = '0;
        for (int i = LINES - 1; i >= 0; i--)
            if (match[i]) lookup_idx = IDX_W'(i);
    end

    assign alloc_idx = lookup_hit ? lookup_idx : lru_idx;
    assign busy      = (state != IDLE);

    // Request sequencing, line storage and every registered output.
    // hit_idx doubles as the working line for the whole request.
    always_ff @(posedge g_clk) begin
        if (!g_clr) begin
            state     <= IDLE;
            req       <= '0;
            valid     <= '0;
`ifdef CACHE_WRITE_BACK_EN
            dirty     <= '0;
`endif
            rdata     <= '0;
            hit       <= 1'b0;
            hit_idx   <= '0;
            done      <= 1'b0;
            touch     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done  <= 1'b0;
            touch <= 1'b0;
            case (state)
                IDLE: if (en) begin
                    req     <= {rw, addr, wdata};
                    hit     <= lookup_hit;
                    hit_idx <= alloc_idx;
                    if (!lookup_hit && victim_dirty) begin
                        // Dirty victim must reach memory before its line is reused.
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= tag[lru_idx];
                        mem_wdata <= line_data[lru_idx];
                        state     <= EVICT;
                    end else if (rw == RW_READ) begin
                        if (lookup_hit) begin
                            rdata <= line_data[lookup_idx];
                            touch <= 1'b1;
                            state <= DONE;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= addr;
                            state    <= FILL;
                        end
                    end else begin
                        // Write-allocate: whole-word lines need no fetch.
                        tag[alloc_idx]       <= addr;
                        line_data[alloc_idx] <= wdata;
                        valid[alloc_idx]     <= 1'b1;
                        touch                <= 1'b1;
`ifdef CACHE_WRITE_BACK_EN
                        dirty[alloc_idx]     <= 1'b1;
                        state                <= DONE;
`else
                        mem_req              <= 1'b1;
                        mem_we               <= 1'b1;
                        mem_addr             <= addr;
                        mem_wdata            <= wdata;
                        state                <= WMEM;
`endif
                    end
                end
                EVICT: if (mem_req && mem_ack) begin
`ifdef CACHE_WRITE_BACK_EN
                    dirty[hit_idx] <= 1'b0;
`endif
                    if (req.rw == RW_READ) begin
                        // Reuse the open request for the fill.
                        mem_we   <= 1'b0;
                        mem_addr <= req.addr;
                        state    <= FILL;
                    end else begin
                        mem_req            <= 1'b0;
                        tag[hit_idx]       <= req.addr;
                        line_data[hit_idx] <= req.wdata;
                        valid[hit_idx]     <= 1'b1;
                        touch              <= 1'b1;
`ifdef CACHE_WRITE_BACK_EN
                        dirty[hit_idx]     <= 1'b1;
`endif
                        state              <= DONE;
                    end
                end
                FILL: if (mem_req && mem_ack) begin
                    mem_req            <= 1'b0;
                    tag[hit_idx]       <= req.addr;
                    line_data[hit_idx] <= mem_rdata;
                    valid[hit_idx]     <= 1'b1;
                    rdata              <= mem_rdata;
                    touch              <= 1'b1;
`ifdef CACHE_WRITE_BACK_EN
                    dirty[hit_idx]     <= 1'b0;
`endif
                    state              <= DONE;
                end
                WMEM: if (mem_req && mem_ack) begin
                    mem_req <= 1'b0;
                    state   <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    lru_tracker #(
        .LINES (LINES),
        .IDX_W (IDX_W)
    ) u_lru (
        .g_clk     (g_clk),
        .g_clr     (g_clr),
        .touch     (touch),
        .touch_idx (hit_idx),
        .valid     (valid),
        .lru_idx   (lru_idx)
    );

endmodule
